// File: rtl/simple_memory.sv
// Single-port synchronous RAM with registered, read-first output.
// One shared address bus serves both the write and the read path. The whole
// array and the output register clear asynchronously while rst_n is low.
module simple_memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // Storage array; every address in the ADDR_W range is backed by a word.
    logic [DATA_W-1:0] mem [DEPTH];

    // Array update: clear every word on reset, otherwise write the addressed word.
    // Because reset is checked before we, a write on the edge where reset is
    // active is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= din;
        end
    end

    // Registered read on every edge. It samples the pre-edge contents, so a
    // read of the word being written returns the old value (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: tb/tb_simple_memory.sv
// Directed self-checking bench for simple_memory.
module tb_simple_memory;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    int checks;
    int errors;

    simple_memory #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a write between edges, then let one rising edge commit it.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        we   = 1'b1;
        addr = a;
        din  = d;
        @(posedge clk);
    endtask

    // Present an address with we=0 and check dout one edge later.
    task automatic rd(input string tag, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] exp);
        @(negedge clk);
        we   = 1'b0;
        addr = a;
        @(posedge clk);
        #1;
        chk($sformatf("%s[%0d]", tag, a), dout, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        we     = 1'b0;
        addr   = '0;
        din    = '0;

        // Reset held across a clock edge
        @(posedge clk);
        #1;
        chk("reset_dout", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) rd("reset_read", i[ADDR_W-1:0], 8'h00);

        // Basic write then read
        wr(4'd1, 8'hA5);
        wr(4'd2, 8'h5A);
        rd("basic", 4'd1, 8'hA5);
        rd("basic", 4'd2, 8'h5A);

        // dout holds between edges even when addr changes
        @(negedge clk);
        addr = 4'd1;
        #2;
        chk("hold", dout, 8'h5A);

        // Isolation of the top word from its neighbours
        wr(4'd15, 8'hFF);
        rd("iso", 4'd0, 8'h00);
        rd("iso", 4'd14, 8'h00);
        rd("iso", 4'd15, 8'hFF);

        // Read-during-write returns the old contents
        wr(4'd3, 8'h11);
        wr(4'd3, 8'h22);
        #1;
        chk("read_first_old", dout, 8'h11);
        rd("read_first_new", 4'd3, 8'h22);

        // Fill all words, then async reset pulse between edges
        for (int i = 0; i < 16; i++) wr(i[ADDR_W-1:0], 8'(i) ^ 8'h30);
        rd("fill", 4'd5, 8'h35);
        @(negedge clk);
        we = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_dout", dout, 8'h00);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) rd("after_async", i[ADDR_W-1:0], 8'h00);

        // A write on an edge while reset is active is discarded
        @(negedge clk);
        rst_n = 1'b0;
        we    = 1'b1;
        addr  = 4'd7;
        din   = 8'h77;
        @(posedge clk);
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
        rd("write_in_reset", 4'd7, 8'h00);

        // Full sweep: write ~addr everywhere, read back in order
        for (int i = 0; i < 16; i++) wr(i[ADDR_W-1:0], 8'hFF ^ 8'(i));
        for (int i = 0; i < 16; i++) rd("sweep", i[ADDR_W-1:0], 8'hFF ^ 8'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
